// File: rtl/conv_stream_engine.sv
// conv_stream_engine: streaming NKERNEL x (K x K) signed convolution over a
// raster-order pixel stream with a strided window step.
// Build option: define CONV_STREAM_RELU_EN to clamp negative results to zero.
module conv_stream_engine #(
  parameter  int DATA_W  = 8,
  parameter  int K       = 3,
  parameter  int IMG_W   = 8,
  parameter  int IMG_H   = 8,
  parameter  int STRIDE  = 1,
  parameter  int NKERNEL = 2,
  localparam int ACC_W   = 2*DATA_W + $clog2(K*K),
  localparam int KSEL_W  = (NKERNEL > 1) ? $clog2(NKERNEL) : 1,
  localparam int WIDX_W  = $clog2(K*K)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       w_we,
  input  logic [KSEL_W-1:0]          w_kernel,
  input  logic [WIDX_W-1:0]          w_index,
  input  logic [DATA_W-1:0]          w_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W-1:0]          s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [NKERNEL*ACC_W-1:0]   m_data,
  output logic                       done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int SW = (K > 1) ? $clog2(K) : 1;
  localparam int PW = 2*DATA_W;

  typedef enum logic [1:0] {IDLE, ACCEPT, MAC, OUT} state_t;

  state_t                     state;
  logic [RW-1:0]              row;
  logic [CW-1:0]              col;
  logic [SW-1:0]              wr_slot;
  logic [SW-1:0]              rd_slot;
  logic [CW-1:0]              win_c0;
  logic [WIDX_W-1:0]          widx;
  logic [SW-1:0]              bcnt;
  logic                       last_seen;
  logic signed [DATA_W-1:0]   lbuf [K][IMG_W];
  logic signed [DATA_W-1:0]   wts  [NKERNEL][K*K];
  logic signed [ACC_W-1:0]    acc  [NKERNEL];

  logic                       row_ok, col_ok, win_done, last_pix;
  logic [CW-1:0]              mac_col;
  logic signed [DATA_W-1:0]   pix;
  logic signed [PW-1:0]       prod [NKERNEL];
  logic signed [ACC_W-1:0]    sum  [NKERNEL];

  // Line buffer rows are used as a ring of K slots; slot of row r is r mod K.
  function automatic logic [SW-1:0] next_slot(input logic [SW-1:0] s);
    return (int'(s) == K-1) ? '0 : s + SW'(1);
  endfunction

  // Input side is open only in the streaming states and never during reset.
  always_comb s_ready = !reset && (state == IDLE || state == ACCEPT);

  // Window completion and end-of-frame detection for the pixel at (row,col).
  always_comb begin
    row_ok   = (int'(row) >= K-1) && (((int'(row) - (K-1)) % STRIDE) == 0);
    col_ok   = (int'(col) >= K-1) && (((int'(col) - (K-1)) % STRIDE) == 0);
    win_done = row_ok && col_ok;
    last_pix = (int'(row) == IMG_H-1) && (int'(col) == IMG_W-1);
  end

  // One window element per MAC cycle, multiplied against every kernel.
  always_comb begin
    mac_col = win_c0 + CW'(bcnt);
    pix     = lbuf[rd_slot][mac_col];
    for (int unsigned n = 0; n < NKERNEL; n++) begin
      prod[n] = PW'(pix) * PW'(wts[n][widx]);
      sum[n]  = acc[n] + ACC_W'(prod[n]);
    end
  end

  // Control FSM, storage, accumulation and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      wr_slot   <= '0;
      rd_slot   <= '0;
      win_c0    <= '0;
      widx      <= '0;
      bcnt      <= '0;
      last_seen <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      done      <= 1'b0;
      for (int unsigned i = 0; i < K; i++)
        for (int unsigned j = 0; j < IMG_W; j++)
          lbuf[i][j] <= '0;
      for (int unsigned n = 0; n < NKERNEL; n++) begin
        acc[n] <= '0;
        for (int unsigned i = 0; i < K*K; i++)
          wts[n][i] <= '0;
      end
    end else begin
      done <= 1'b0;
      if (state == IDLE && w_we && int'(w_kernel) < NKERNEL && int'(w_index) < K*K)
        wts[w_kernel][w_index] <= w_data;
      case (state)
        IDLE, ACCEPT: begin
          if (s_valid) begin
            lbuf[wr_slot][col] <= s_data;
            if (last_pix) begin
              row     <= '0;
              col     <= '0;
              wr_slot <= '0;
            end else if (int'(col) == IMG_W-1) begin
              col     <= '0;
              row     <= row + RW'(1);
              wr_slot <= next_slot(wr_slot);
            end else begin
              col <= col + CW'(1);
            end
            if (win_done) begin
              // Window geometry is latched so the counters can move on.
              state     <= MAC;
              win_c0    <= col - CW'(K-1);
              rd_slot   <= next_slot(wr_slot);
              widx      <= '0;
              bcnt      <= '0;
              last_seen <= last_pix;
              for (int unsigned n = 0; n < NKERNEL; n++)
                acc[n] <= '0;
            end else if (last_pix) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              state <= ACCEPT;
            end
          end
        end
        MAC: begin
          for (int unsigned n = 0; n < NKERNEL; n++)
            acc[n] <= sum[n];
          if (widx == WIDX_W'(K*K-1)) begin
            state   <= OUT;
            m_valid <= 1'b1;
            for (int unsigned n = 0; n < NKERNEL; n++) begin
`ifdef CONV_STREAM_RELU_EN
              m_data[n*ACC_W +: ACC_W] <= sum[n][ACC_W-1] ? '0 : sum[n];
`else
              m_data[n*ACC_W +: ACC_W] <= sum[n];
`endif
            end
          end else begin
            widx <= widx + WIDX_W'(1);
            if (bcnt == SW'(K-1)) begin
              bcnt    <= '0;
              rd_slot <= next_slot(rd_slot);
            end else begin
              bcnt <= bcnt + SW'(1);
            end
          end
        end
        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (last_seen) begin
              state     <= IDLE;
              done      <= 1'b1;
              last_seen <= 1'b0;
            end else begin
              state <= ACCEPT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_stream_engine.sv
// Self-checking bench for conv_stream_engine: constant-frame vector table,
// stride-2 instance, stall / weight-write / reset corner cases, random frames
// checked against a window-sum reference model.
module tb_conv_stream_engine;

  localparam int DW   = 8;
  localparam int K    = 3;
  localparam int IW   = 8;
  localparam int IH   = 8;
  localparam int NK   = 2;
  localparam int AW   = 2*DW + $clog2(K*K);
  localparam int NPIX = IW*IH;
`ifdef CONV_STREAM_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  typedef struct { int w0; int w1; int p; int e0; int e1; } vec_t;

  logic              clock = 1'b0;
  logic              reset, sel, w_we, s_valid, m_ready, w_kernel;
  logic [3:0]        w_index;
  logic [DW-1:0]     w_data, s_data;
  logic              s_ready0, s_ready1, m_valid0, m_valid1, done0, done1;
  logic [NK*AW-1:0]  m_data0, m_data1;
  logic              rdy, mv, dn;
  logic [NK*AW-1:0]  md;

  int                checks = 0;
  int                errors = 0;
  int                img [IH][IW];
  int                wm  [NK][K*K];
  logic [NK*AW-1:0]  expq [$];
  logic [NK*AW-1:0]  first_out;
  vec_t              tbl [5];
  bit                found;

  always #5 clock = ~clock;

  assign rdy = sel ? s_ready1 : s_ready0;
  assign mv  = sel ? m_valid1 : m_valid0;
  assign dn  = sel ? done1    : done0;
  assign md  = sel ? m_data1  : m_data0;

  conv_stream_engine dut0 (
    .clock(clock), .reset(reset), .w_we(w_we & ~sel), .w_kernel(w_kernel),
    .w_index(w_index), .w_data(w_data), .s_valid(s_valid & ~sel),
    .s_ready(s_ready0), .s_data(s_data), .m_valid(m_valid0),
    .m_ready(m_ready & ~sel), .m_data(m_data0), .done(done0));

  conv_stream_engine #(.STRIDE(2)) dut1 (
    .clock(clock), .reset(reset), .w_we(w_we & sel), .w_kernel(w_kernel),
    .w_index(w_index), .w_data(w_data), .s_valid(s_valid & sel),
    .s_ready(s_ready1), .s_data(s_data), .m_valid(m_valid1),
    .m_ready(m_ready & sel), .m_data(m_data1), .done(done1));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_);
    checks++;
    if (act !== exp_) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp_, exp_);
    end
  endtask

  // Reference: every strided window, plain dot product per kernel.
  function automatic void fill_exp(input int stride);
    logic [NK*AW-1:0] v;
    int s;
    expq.delete();
    for (int r0 = 0; r0 + K <= IH; r0 += stride)
      for (int c0 = 0; c0 + K <= IW; c0 += stride) begin
        v = '0;
        for (int n = 0; n < NK; n++) begin
          s = 0;
          for (int a = 0; a < K; a++)
            for (int b = 0; b < K; b++)
              s += img[r0+a][c0+b] * wm[n][a*K+b];
          if (RELU && s < 0) s = 0;
          v[n*AW +: AW] = AW'(s);
        end
        expq.push_back(v);
      end
  endfunction

  task automatic set_w(input int k0, input int k1);
    for (int i = 0; i < K*K; i++) begin wm[0][i] = k0; wm[1][i] = k1; end
  endtask

  task automatic rand_w();
    for (int n = 0; n < NK; n++)
      for (int i = 0; i < K*K; i++) wm[n][i] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic const_img(input int p);
    for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) img[r][c] = p;
  endtask

  task automatic rand_img();
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++) img[r][c] = int'($urandom_range(0, 255)) - 128;
  endtask

  // Writes the model weights into both instances (both idle).
  task automatic load_all();
    for (int s = 0; s < 2; s++)
      for (int n = 0; n < NK; n++)
        for (int i = 0; i < K*K; i++) begin
          @(negedge clock);
          sel = s[0]; w_we = 1'b1; w_kernel = n[0]; w_index = 4'(i); w_data = 8'(wm[n][i]);
        end
    @(negedge clock);
    w_we = 1'b0;
  endtask

  task automatic run_frame(input bit fast, input bit stall_first, input bit poke_mac, input bit first_w);
    int pix = 0, nout, outn = 0, cyc = 0, first_acc = -1, first_mv = -1;
    int done_at = -1, stall = 0, stage = 0;
    logic [NK*AW-1:0] held = '0, e;
    nout = expq.size();
    while (stage < 3 && cyc < 20000) begin
      @(negedge clock);
      s_valid = (pix < NPIX) && (fast || ($urandom_range(0, 3) != 0));
      s_data  = (pix < NPIX) ? 8'(img[pix/IW][pix%IW]) : '0;
      m_ready = fast || ($urandom_range(0, 2) != 0);
      w_we    = 1'b0;
      if (first_w && pix == 0) begin
        w_we = 1'b1; w_kernel = 1'b1; w_index = 4'd4; w_data = 8'(wm[1][4]);
      end
      if (poke_mac && first_acc >= 0 && stage == 0 && !rdy && !mv) begin
        w_we = 1'b1; w_kernel = 1'b0; w_index = 4'd0; w_data = 8'd7;
      end
      if (stall_first && mv && stall < 5) m_ready = 1'b0;
      #1;
      if (stage == 1) begin
        chk("done_pulse", dn, 1);
        chk("idle_ready", rdy, 1);
        done_at = cyc;
      end else begin
        chk("done_quiet", dn, 0);
      end
      if (stage == 2) stage = 3;
      if (stall_first && mv && stall < 5) begin
        if (stall == 0) held = md;
        else chk("stall_hold", md, held);
        chk("stall_ready", rdy, 0);
        stall++;
      end
      if (mv && m_ready) begin
        if (expq.size() == 0) chk("extra_output", 1, 0);
        else begin
          e = expq.pop_front();
          chk("m_data", md, e);
        end
        if (outn == 0) first_out = md;
        outn++;
      end
      if (mv && first_mv < 0) first_mv = cyc;
      if (s_valid && rdy) begin
        if (first_acc < 0) first_acc = cyc;
        pix++;
      end
      if (stage == 1) stage = 2;
      else if (stage == 0 && pix == NPIX && outn == nout) stage = 1;
      cyc++;
    end
    s_valid = 1'b0; m_ready = 1'b0; w_we = 1'b0;
    chk("frame_end", stage, 3);
    chk("outputs_left", expq.size(), 0);
    if (stall_first) chk("stall_cycles", stall, 5);
    if (fast) begin
      chk("latency", first_mv - first_acc, (K-1)*IW + (K-1) + K*K + 1);
      chk("frame_cycles", done_at - first_acc, NPIX + nout*(K*K+1));
    end
  endtask

  initial begin
    tbl[0] = '{1, 1, 1, 9, 9};
    tbl[1] = '{-1, 2, 5, RELU ? 0 : -45, 90};
    tbl[2] = '{3, -2, -7, RELU ? 0 : -189, 126};
    tbl[3] = '{127, -128, -128, RELU ? 0 : -146304, 147456};
    tbl[4] = '{0, 1, -1, 0, RELU ? 0 : -9};

    sel = 1'b0; w_we = 1'b0; w_kernel = 1'b0; w_index = '0; w_data = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0; reset = 1'b1;
    #1;
    chk("rst_ready0", s_ready0, 0);
    chk("rst_ready1", s_ready1, 0);
    chk("rst_valid0", m_valid0, 0);
    chk("rst_done0", done0, 0);
    chk("rst_data0", m_data0, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("ready_after_rst0", s_ready0, 1);
    chk("ready_after_rst1", s_ready1, 1);

    // Constant-frame vector table on the stride-1 instance.
    for (int t = 0; t < 5; t++) begin
      sel = 1'b0;
      set_w(tbl[t].w0, tbl[t].w1);
      load_all();
      const_img(tbl[t].p);
      expq.delete();
      repeat (36) expq.push_back({AW'(tbl[t].e1), AW'(tbl[t].e0)});
      sel = 1'b0;
      run_frame(1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Stride 2, ramp image.
    set_w(1, 1);
    load_all();
    for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) img[r][c] = r*8 + c;
    fill_exp(2);
    sel = 1'b1;
    run_frame(1'b1, 1'b0, 1'b0, 1'b0);
    chk("stride2_first_k0", first_out[AW-1:0], 81);
    chk("stride2_first_k1", first_out[2*AW-1:AW], 81);

    // Output stall on the first result.
    rand_w();
    wm[0][0] = -3;
    load_all();
    sel = 1'b0;
    rand_img();
    fill_exp(1);
    run_frame(1'b0, 1'b1, 1'b0, 1'b0);

    // Weight write during MAC is ignored.
    rand_img();
    fill_exp(1);
    run_frame(1'b0, 1'b0, 1'b1, 1'b0);

    // Same write while idle changes the next frame.
    wm[0][0] = 7;
    load_all();
    sel = 1'b0;
    rand_img();
    fill_exp(1);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);

    // Write in the same cycle as the first pixel is used by the first MAC.
    wm[1][4] = (wm[1][4] == -77) ? 55 : -77;
    rand_img();
    fill_exp(1);
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);

    // Random frames on both instances.
    for (int i = 0; i < 4; i++) begin
      rand_w();
      load_all();
      sel = i[0];
      rand_img();
      fill_exp(i[0] ? 2 : 1);
      run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Reset in the middle of MAC.
    rand_w();
    wm[0][0] = 5;
    load_all();
    sel = 1'b0;
    rand_img();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clock);
      s_valid = 1'b1; m_ready = 1'b1; s_data = 8'(img[i/IW][i%IW]);
      #1;
      if (!s_ready0) found = 1'b1;
    end
    chk("reach_mac", found, 1);
    @(negedge clock);
    reset = 1'b1; s_valid = 1'b0;
    #1;
    chk("mid_rst_valid", m_valid0, 0);
    chk("mid_rst_done", done0, 0);
    chk("mid_rst_ready", s_ready0, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("mid_rst_release_ready", s_ready0, 1);
    set_w(0, 0);
    rand_img();
    fill_exp(1);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    sel = 1'b1;
    rand_img();
    fill_exp(2);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
